// File: rtl/img_proc_pkg.sv
// Shared constants and helpers for the image-processing pipeline.
// Holds the BT.601 full-range coefficients, the chroma offset, the rounding
// constant and the common pipeline latency used by the colour converter and
// by later stages that reuse sync_delay.
package img_proc_pkg;

  // Pipeline latency, in clk cycles, from sampled input to registered output.
  localparam int unsigned PIPE_LAT = 3;

  // Luma coefficients (x256).
  localparam logic [7:0] C_Y_R  = 8'd77;
  localparam logic [7:0] C_Y_G  = 8'd150;
  localparam logic [7:0] C_Y_B  = 8'd29;
  // Cb coefficients (x256); R and G terms are subtracted.
  localparam logic [7:0] C_CB_R = 8'd43;
  localparam logic [7:0] C_CB_G = 8'd85;
  localparam logic [7:0] C_CB_B = 8'd128;
  // Cr coefficients (x256); G and B terms are subtracted.
  localparam logic [7:0] C_CR_R = 8'd128;
  localparam logic [7:0] C_CR_G = 8'd107;
  localparam logic [7:0] C_CR_B = 8'd21;

  // Signed accumulator wide enough for every sum plus rounding.
  typedef logic signed [18:0] sum_t;

  localparam sum_t C_OFFSET = 19'sd32768;
  localparam sum_t C_ROUND  = 19'sd128;

  // Frame/line/pixel qualifiers travelling alongside the data.
  typedef struct packed {
    logic vsync;
    logic href;
    logic clken;
  } sync_t;

  // Constant-coefficient 8x8 unsigned product.
  function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
    return 16'(a) * 16'(b);
  endfunction

  // Zero-extend a product into the signed accumulator domain.
  function automatic sum_t ext16(input logic [15:0] p);
    return sum_t'({3'b000, p});
  endfunction

  // Clamp a signed value to [0,255] with no wrap-around.
  function automatic logic [7:0] sat_u8(input sum_t v);
    logic [7:0] r;
    if (v[18])
      r = '0;
    else if (|v[17:8])
      r = '1;
    else
      r = v[7:0];
    return r;
  endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register for frame/line/pixel qualifiers.
// Keeps sync signals cycle-aligned with a data pipeline of the same depth.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, clears every stage
//   din_i  - WIDTH-bit sync bundle sampled every clk
//   dout_o - din_i delayed by exactly DEPTH clk
module sync_delay #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= din_i;
      for (int unsigned i = 1; i < DEPTH; i++)
        pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/rgb888_to_ycbcr.sv
// RGB888 to YCbCr (BT.601 full range) converter, 3-stage free-running pipeline.
//   stage 1: nine constant products
//   stage 2: signed Y/Cb/Cr sums (chroma offset 32768 added)
//   stage 3: optional rounding, >>8, clamp to [0,255]
// The pipeline never stalls; pos_img_* is meaningful only while
// pos_frame_href & pos_frame_clken are high.
// Ports:
//   clk, rst_n                          - clock, async active-low reset
//   per_frame_vsync/href/clken          - input syncs
//   per_img_red/green/blue              - RGB888 pixel
//   pos_frame_vsync/href/clken          - syncs delayed by PIPE_LAT
//   pos_img_y/cb/cr                     - YCbCr pixel
module rgb888_to_ycbcr
  import img_proc_pkg::*;
#(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_red,
  input  logic [7:0] per_img_green,
  input  logic [7:0] per_img_blue,
  output logic       pos_frame_vsync,
  output logic       pos_frame_href,
  output logic       pos_frame_clken,
  output logic [7:0] pos_img_y,
  output logic [7:0] pos_img_cb,
  output logic [7:0] pos_img_cr
);

  // Stage 1: products, index order Y(R,G,B), Cb(R,G,B), Cr(R,G,B).
  logic [15:0] prod_d [9];
  logic [15:0] prod_q [9];

  always_comb begin
    prod_d[0] = mul8(per_img_red,   C_Y_R);
    prod_d[1] = mul8(per_img_green, C_Y_G);
    prod_d[2] = mul8(per_img_blue,  C_Y_B);
    prod_d[3] = mul8(per_img_red,   C_CB_R);
    prod_d[4] = mul8(per_img_green, C_CB_G);
    prod_d[5] = mul8(per_img_blue,  C_CB_B);
    prod_d[6] = mul8(per_img_red,   C_CR_R);
    prod_d[7] = mul8(per_img_green, C_CR_G);
    prod_d[8] = mul8(per_img_blue,  C_CR_B);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 9; i++)
        prod_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 9; i++)
        prod_q[i] <= prod_d[i];
    end
  end

  // Stage 2: signed sums.
  sum_t y_d, cb_d, cr_d;
  sum_t y_q, cb_q, cr_q;

  always_comb begin
    y_d  = ext16(prod_q[0]) + ext16(prod_q[1]) + ext16(prod_q[2]);
    cb_d = ext16(prod_q[5]) - ext16(prod_q[3]) - ext16(prod_q[4]) + C_OFFSET;
    cr_d = ext16(prod_q[6]) - ext16(prod_q[7]) - ext16(prod_q[8]) + C_OFFSET;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q  <= '0;
      cb_q <= '0;
      cr_q <= '0;
    end else begin
      y_q  <= y_d;
      cb_q <= cb_d;
      cr_q <= cr_d;
    end
  end

  // Stage 3: round, arithmetic shift, saturate.
  sum_t       rnd;
  sum_t       y_r, cb_r, cr_r;
  logic [7:0] y_o_d, cb_o_d, cr_o_d;
  logic [7:0] y_o_q, cb_o_q, cr_o_q;

  always_comb begin
    rnd    = ROUND_EN ? C_ROUND : sum_t'(0);
    y_r    = y_q  + rnd;
    cb_r   = cb_q + rnd;
    cr_r   = cr_q + rnd;
    y_o_d  = sat_u8(y_r  >>> 8);
    cb_o_d = sat_u8(cb_r >>> 8);
    cr_o_d = sat_u8(cr_r >>> 8);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_o_q  <= '0;
      cb_o_q <= '0;
      cr_o_q <= '0;
    end else begin
      y_o_q  <= y_o_d;
      cb_o_q <= cb_o_d;
      cr_o_q <= cr_o_d;
    end
  end

  assign pos_img_y  = y_o_q;
  assign pos_img_cb = cb_o_q;
  assign pos_img_cr = cr_o_q;

  // Syncs run in their own shift register, same depth as the data path.
  sync_t sync_in, sync_out;

  assign sync_in = '{vsync: per_frame_vsync, href: per_frame_href, clken: per_frame_clken};

  sync_delay #(
    .DEPTH(PIPE_LAT),
    .WIDTH($bits(sync_t))
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din_i (sync_in),
    .dout_o(sync_out)
  );

  assign pos_frame_vsync = sync_out.vsync;
  assign pos_frame_href  = sync_out.href;
  assign pos_frame_clken = sync_out.clken;

endmodule

// File: tb/tb_rgb888_to_ycbcr.sv
module tb_rgb888_to_ycbcr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       per_frame_vsync = 1'b0;
  logic       per_frame_href  = 1'b0;
  logic       per_frame_clken = 1'b0;
  logic [7:0] per_img_red   = '0;
  logic [7:0] per_img_green = '0;
  logic [7:0] per_img_blue  = '0;
  logic       pos_frame_vsync, pos_frame_href, pos_frame_clken;
  logic [7:0] pos_img_y, pos_img_cb, pos_img_cr;

  always #5 clk = ~clk;

  rgb888_to_ycbcr #(.ROUND_EN(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .per_frame_vsync(per_frame_vsync),
    .per_frame_href (per_frame_href),
    .per_frame_clken(per_frame_clken),
    .per_img_red    (per_img_red),
    .per_img_green  (per_img_green),
    .per_img_blue   (per_img_blue),
    .pos_frame_vsync(pos_frame_vsync),
    .pos_frame_href (pos_frame_href),
    .pos_frame_clken(pos_frame_clken),
    .pos_img_y      (pos_img_y),
    .pos_img_cb     (pos_img_cb),
    .pos_img_cr     (pos_img_cr)
  );

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   expected_outs = 0;
  int   popped = 0;
  logic [2:0] h0 = '0, h1 = '0, h2 = '0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Directed vector table: rgb in, hand-computed ycbcr out.
  typedef struct packed {
    logic [7:0] r, g, b, y, cb, cr;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC] = '{
    '{r:8'd200, g:8'd200, b:8'd200, y:8'd200, cb:8'd128, cr:8'd128},
    '{r:8'd255, g:8'd0,   b:8'd0,   y:8'd77,  cb:8'd85,  cr:8'd255},
    '{r:8'd0,   g:8'd0,   b:8'd255, y:8'd29,  cb:8'd255, cr:8'd107},
    '{r:8'd0,   g:8'd0,   b:8'd0,   y:8'd0,   cb:8'd128, cr:8'd128},
    '{r:8'd255, g:8'd255, b:8'd255, y:8'd255, cb:8'd128, cr:8'd128},
    '{r:8'd0,   g:8'd255, b:8'd0,   y:8'd149, cb:8'd43,  cr:8'd21},
    '{r:8'd100, g:8'd50,  b:8'd25,  y:8'd62,  cb:8'd107, cr:8'd155},
    '{r:8'd10,  g:8'd200, b:8'd50,  y:8'd126, cb:8'd85,  cr:8'd45},
    '{r:8'd1,   g:8'd1,   b:8'd1,   y:8'd1,   cb:8'd128, cr:8'd128}
  };

  task automatic drive(input logic vs, input logic hr, input logic ck,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic [7:0] ey, input logic [7:0] ecb, input logic [7:0] ecr);
    @(negedge clk);
    per_frame_vsync = vs;
    per_frame_href  = hr;
    per_frame_clken = ck;
    per_img_red     = r;
    per_img_green   = g;
    per_img_blue    = b;
    if (hr && ck) begin
      sb.push_back('{y:ey, cb:ecb, cr:ecr});
      expected_outs++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
  endtask

  // Monitor: sync outputs must equal inputs sampled three edges back;
  // qualified pixels are compared against the scoreboard in order.
  initial begin
    logic [2:0] cap;
    exp_t e;
    forever begin
      @(posedge clk);
      cap = {per_frame_vsync, per_frame_href, per_frame_clken};
      if (!rst_n) begin
        h0 = '0; h1 = '0; h2 = '0;
      end else begin
        h2 = h1; h1 = h0; h0 = cap;
      end
      #1;
      check8("sync", {5'b0, pos_frame_vsync, pos_frame_href, pos_frame_clken}, {5'b0, h2});
      if (pos_frame_href && pos_frame_clken) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stale_pixel: got y=%0d cb=%0d cr=%0d expected no pixel at %0t",
                   pos_img_y, pos_img_cb, pos_img_cr, $time);
        end else begin
          e = sb.pop_front();
          popped++;
          check8("y",  pos_img_y,  e.y);
          check8("cb", pos_img_cb, e.cb);
          check8("cr", pos_img_cr, e.cr);
        end
      end
    end
  end

  initial begin
    int wait_cnt;
    logic [7:0] v;

    // Reset state.
    #12;
    check8("rst_y",  pos_img_y,  8'd0);
    check8("rst_cb", pos_img_cb, 8'd0);
    check8("rst_cr", pos_img_cr, 8'd0);
    check8("rst_sync", {5'b0, pos_frame_vsync, pos_frame_href, pos_frame_clken}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Back-to-back directed vectors.
    for (int i = 0; i < NVEC; i++)
      drive(1'b1, 1'b1, 1'b1, vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].y, vecs[i].cb, vecs[i].cr);
    // Unqualified data must not produce output pixels.
    drive(1'b1, 1'b1, 1'b0, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0);
    drive(1'b1, 1'b0, 1'b1, 8'd9, 8'd9, 8'd9, 8'd0, 8'd0, 8'd0);
    drive(1'b1, 1'b1, 1'b1, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128);
    idle(4);

    // Small frame: 4 lines, 10-cycle blanking each side, clken toggling.
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    for (int ln = 0; ln < 4; ln++) begin
      for (int j = 0; j < 10; j++)
        drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
      for (int j = 0; j < 16; j++) begin
        v = 8'(ln * 40 + j * 7);
        drive(1'b1, 1'b1, 1'(j % 2), v, v, v, v, 8'd128, 8'd128);
      end
      for (int j = 0; j < 10; j++)
        drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    end
    idle(5);

    // Mid-line reset: in-flight pixels are discarded.
    drive(1'b1, 1'b1, 1'b1, 8'd60, 8'd60, 8'd60, 8'd60, 8'd128, 8'd128);
    drive(1'b1, 1'b1, 1'b1, 8'd70, 8'd70, 8'd70, 8'd70, 8'd128, 8'd128);
    #2;
    rst_n = 1'b0;
    #1;
    check8("midrst_y",  pos_img_y,  8'd0);
    check8("midrst_cb", pos_img_cb, 8'd0);
    check8("midrst_cr", pos_img_cr, 8'd0);
    check8("midrst_sync", {5'b0, pos_frame_vsync, pos_frame_href, pos_frame_clken}, 8'd0);
    expected_outs -= sb.size();
    sb.delete();
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(6);

    // Recovery after reset.
    drive(1'b1, 1'b1, 1'b1, 8'd50, 8'd50, 8'd50, 8'd50, 8'd128, 8'd128);
    drive(1'b1, 1'b1, 1'b1, 8'd255, 8'd0, 8'd0, 8'd77, 8'd85, 8'd255);
    idle(1);

    // Bounded drain.
    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    idle(2);
    checks++;
    if (popped != expected_outs) begin
      errors++;
      $display("FAIL pixel_count: got %0d expected %0d", popped, expected_outs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
